cache_req_sched: RTL and testbench
==================================

# cache_req_sched

Request scheduler and miss sequencer in front of the 2-way set-associative cache. It arbitrates between NREQ requesters with round-robin priority and issues one lookup at a time to the cache. On a miss it fetches the word from backing memory over a valid/ready handshake, fills the cache, and returns data to the granted requester. It sits between the core-side request ports and the cache/memory pair.

## Interface
- NREQ, 2: number of requesters (2..4)
- ADDR_W, 32: address width
- DATA_W, 32: data width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  request present, per requester
- req_addr  in  NREQ x ADDR_W  request byte address, per requester
- req_ready  out  NREQ  one-hot grant/accept
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe
- rsp_data  out  DATA_W  response data, shared
- rsp_hit  out  1  1 = served from cache, 0 = refilled
- c_lookup  out  1  cache lookup strobe
- c_addr  out  ADDR_W  lookup/fill address
- c_hit  in  1  lookup result, valid combinationally while c_lookup=1
- c_data  in  DATA_W  hit data, valid with c_hit
- c_fill  out  1  one-cycle fill strobe
- c_fill_data  out  DATA_W  fill data
- mem_req_valid  out  1  memory read request
- mem_req_addr  out  ADDR_W  word-aligned read address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory read data valid
- mem_rsp_data  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP.
- IDLE: the round-robin arbiter picks one valid requester g. req_ready[g]=1 combinationally, and no other bit is set. On req_valid[g]&&req_ready[g]: capture addr and g, advance the pointer so that g becomes lowest priority, then go to LOOKUP. With no valid request, stay in IDLE.
- LOOKUP: c_lookup=1, c_addr=captured addr. If c_hit=1, capture c_data, set hit flag, go to RESP. Otherwise go to MEM_REQ.
- MEM_REQ: mem_req_valid=1, mem_req_addr={addr[ADDR_W-1:2],2'b00}, held stable until mem_req_ready=1, then go to MEM_WAIT.
- MEM_WAIT: wait for mem_rsp_valid, capture mem_rsp_data, go to FILL. mem_rsp_valid in any other state is ignored.
- FILL: c_fill=1, c_addr=captured addr, c_fill_data=captured data, then go to RESP.
- RESP: rsp_valid[g]=1, rsp_data=captured data, rsp_hit=hit flag, then go to IDLE. Responses have no backpressure.
- Only one transaction is in flight. Requests arriving while busy wait with req_ready=0. Requesters must hold req_valid/req_addr until accepted.

## Timing
- Reset values: state IDLE, pointer 0 (requester 0 highest), req_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_hit=0, c_lookup=0, c_fill=0, mem_req_valid=0, c_addr=0, mem_req_addr=0.
- Hit latency: accept in cycle T, LOOKUP in T+1, rsp_valid in T+2. The next accept is possible in T+3.
- Miss latency: T+2+Wr+Wm+1 to RESP, where Wr is the number of cycles mem_req_valid waits for ready (min 1) and Wm is the number of cycles from the request handshake to mem_rsp_valid (min 1). Minimum is 5 cycles accept-to-response.
- Simultaneous requests: the highest-priority requester after the pointer wins. Pointer = (g+1) mod NREQ after each accept.
- Reset mid-operation, in any state: return to IDLE next edge with all strobes low. Any pending memory response is dropped, and no response is issued for the aborted request.
- All outputs other than req_ready are registered or decoded from state and registers only.

## Configuration
- CACHE_SCHED_PERF_EN defined: adds outputs hit_cnt and miss_cnt (32 bits each). They increment in LOOKUP on hit or miss respectively, saturate at all-ones, and clear on reset.
- Not defined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package cache_pkg: state enum type, ADDR_W/DATA_W defaults, word-align helper function.
- Sub-module rr_arbiter: NREQ-wide request vector plus pointer, giving a one-hot grant. The pointer update lives in cache_req_sched.

## Test plan
- Single hit: req0 addr 0x40, c_hit=1, c_data=0xDEAD -> rsp_valid[0] two cycles after accept, rsp_data=0xDEAD, rsp_hit=1, no mem_req_valid.
- Miss with stalls: req1 addr 0x1236, c_hit=0, mem_req_ready low 3 cycles, mem_rsp_data=0x55AA after 4 cycles -> mem_req_addr=0x1234 held stable, c_fill=1 with c_fill_data=0x55AA, then rsp_valid[1], rsp_hit=0.
- Contention: req0 and req1 valid continuously, all hits -> grants alternate 0,1,0,1, starting with 0 after reset.
- Reset in MEM_WAIT: rst=0 for one cycle, then mem_rsp_valid pulses -> no c_fill, no rsp_valid, FSM in IDLE, next request served normally.
- Spurious memory response: mem_rsp_valid pulses in IDLE -> ignored, all outputs unchanged.
- With CACHE_SCHED_PERF_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2. Both counters read 0 after reset.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache request scheduler.
package cache_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FILL     = 3'd4,
        ST_RESP     = 3'd5
    } sched_state_e;

    // Clear the byte offset so memory always sees a word address.
    function automatic logic [MAX_ADDR_W-1:0] word_align(input logic [MAX_ADDR_W-1:0] a);
        return a & ~MAX_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after ptr.
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan requesters starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_req_sched.sv
// Request scheduler and miss sequencer in front of a 2-way cache.
// Round-robin arbitration over NREQ requesters, one transaction in flight,
// misses refilled from memory over a valid/ready handshake.
// Optional: define CACHE_SCHED_PERF_EN to add saturating hit/miss counters.
module cache_req_sched
    import cache_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_hit,
    output logic                         c_lookup,
    output logic [ADDR_W-1:0]            c_addr,
    input  logic                         c_hit,
    input  logic [DATA_W-1:0]            c_data,
    output logic                         c_fill,
    output logic [DATA_W-1:0]            c_fill_data,
    output logic                         mem_req_valid,
    output logic [ADDR_W-1:0]            mem_req_addr,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_W-1:0]            mem_rsp_data
`ifdef CACHE_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [CNT_W-1:0]             miss_cnt
`endif
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e       state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   own_q, own_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               hit_q, hit_d;

    logic [NREQ-1:0]    gnt;
    logic [PTR_W-1:0]   gidx;
    logic               accept;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (gnt)
    );

    // Grant is only offered while idle and out of reset.
    assign req_ready = (rst && (state_q == ST_IDLE)) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);

    // Encode the one-hot grant into a requester index.
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

    // State and transaction context registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state and context update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hit_d   = hit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr[gidx];
                    own_d   = gidx;
                    ptr_d   = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (c_hit) begin
                    data_d  = c_data;
                    hit_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    hit_d   = 1'b0;
                    state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_data;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_lookup      <= 1'b0;
            c_fill        <= 1'b0;
            c_addr        <= '0;
            c_fill_data   <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_hit       <= 1'b0;
        end else begin
            c_lookup      <= (state_d == ST_LOOKUP);
            c_fill        <= (state_d == ST_FILL);
            c_addr        <= ((state_d == ST_LOOKUP) || (state_d == ST_FILL)) ? addr_d : '0;
            c_fill_data   <= (state_d == ST_FILL) ? data_d : '0;
            mem_req_valid <= (state_d == ST_MEM_REQ);
            mem_req_addr  <= (state_d == ST_MEM_REQ)
                             ? ADDR_W'(word_align(MAX_ADDR_W'(addr_d))) : '0;
            rsp_valid     <= (state_d == ST_RESP) ? (NREQ'(1) << own_d) : '0;
            rsp_data      <= (state_d == ST_RESP) ? data_d : '0;
            rsp_hit       <= (state_d == ST_RESP) ? hit_d : 1'b0;
        end
    end

`ifdef CACHE_SCHED_PERF_EN
    // Saturating lookup outcome counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (c_hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_sched.sv
// Directed bench for cache_req_sched: vector table plus corner-case sequences.
module tb_cache_req_sched;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_hit;
    logic              c_lookup;
    logic [31:0]       c_addr;
    logic              c_hit;
    logic [31:0]       c_data;
    logic              c_fill;
    logic [31:0]       c_fill_data;
    logic              mem_req_valid;
    logic [31:0]       mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
`ifdef CACHE_SCHED_PERF_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cache_req_sched #(.NREQ(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_hit       (rsp_hit),
        .c_lookup      (c_lookup),
        .c_addr        (c_addr),
        .c_hit         (c_hit),
        .c_data        (c_data),
        .c_fill        (c_fill),
        .c_fill_data   (c_fill_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
`ifdef CACHE_SCHED_PERF_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        hit;
        logic [31:0] data;
        int          wr;
        int          wm;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          w;
        int          m;
        bit          rdy_drv;
        bit          in_wait;
        bit          saw_mreq;
        bit          saw_fill;
        bit          done;
        logic [31:0] la;
        w = 0; m = 0; rdy_drv = 0; in_wait = 0; saw_mreq = 0; saw_fill = 0; done = 0;
        la = (v.exp_gnt == 2'b01) ? v.a0 : v.a1;
        @(negedge clk);
        req_valid     = v.mask;
        req_addr[0]   = v.a0;
        req_addr[1]   = v.a1;
        c_hit         = v.hit;
        c_data        = v.hit ? v.data : 32'h0BAD_0BAD;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = v.data;
        #1;
        chk("req_ready", 64'(req_ready), 64'(v.exp_gnt));
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req_valid = 2'b00;
                chk("lookup_strobe", 64'(c_lookup), 64'(1));
                chk("lookup_addr", 64'(c_addr), 64'(la));
            end
            if (rdy_drv) begin
                in_wait = 1;
                m       = 0;
                rdy_drv = 0;
            end
            mem_rsp_valid = 1'b0;
            if (in_wait) begin
                m++;
                if (m == v.wm) begin
                    mem_rsp_valid = 1'b1;
                    in_wait       = 0;
                end
            end
            if (mem_req_valid) begin
                saw_mreq = 1;
                chk("mem_req_addr", 64'(mem_req_addr), 64'(v.exp_maddr));
                w++;
                mem_req_ready = (w == v.wr);
                if (w == v.wr) rdy_drv = 1;
            end else begin
                mem_req_ready = 1'b0;
            end
            if (c_fill) begin
                saw_fill = 1;
                chk("fill_data", 64'(c_fill_data), 64'(v.data));
                chk("fill_addr", 64'(c_addr), 64'(la));
            end
            if (rsp_valid != 2'b00) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(v.exp_gnt));
                chk("rsp_data", 64'(rsp_data), 64'(v.data));
                chk("rsp_hit", 64'(rsp_hit), 64'(v.hit));
                chk("latency", 64'(cyc), v.hit ? 64'(2) : 64'(3 + v.wr + v.wm));
                done = 1;
                break;
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk("rsp_timeout", 64'(done), 64'(1));
        chk("mem_req_seen", 64'(saw_mreq), 64'(!v.hit));
        chk("fill_seen", 64'(saw_fill), 64'(!v.hit));
    endtask

    task automatic chk_quiet(input string name);
        chk(name, 64'({rsp_valid, rsp_hit, c_lookup, c_fill, mem_req_valid, req_ready}), 64'(0));
    endtask

    initial begin
        int exp_hits;
        int exp_miss;
        bit got;
        bit seen;

        //        mask   a0            a1            hit   data          wr wm gnt    maddr
        vecs[0] = '{2'b01, 32'h0000_0040, 32'h0,        1'b1, 32'h0000_DEAD, 0, 0, 2'b01, 32'h0};
        vecs[1] = '{2'b10, 32'h0,         32'h0000_1236, 1'b0, 32'h0000_55AA, 4, 4, 2'b10, 32'h0000_1234};
        vecs[2] = '{2'b11, 32'h0000_0100, 32'h0000_0200, 1'b1, 32'h0000_1111, 0, 0, 2'b01, 32'h0};
        vecs[3] = '{2'b11, 32'h0000_0104, 32'h0000_0207, 1'b0, 32'h0000_2222, 1, 1, 2'b10, 32'h0000_0204};
        vecs[4] = '{2'b10, 32'h0,         32'h0000_0300, 1'b1, 32'h0000_3333, 0, 0, 2'b10, 32'h0};
        vecs[5] = '{2'b11, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h0000_4444, 0, 0, 2'b01, 32'h0};
        vecs[6] = '{2'b01, 32'hFFFF_FFFF, 32'h0,        1'b0, 32'hCAFE_F00D, 2, 3, 2'b01, 32'hFFFF_FFFC};
        vecs[7] = '{2'b11, 32'h0000_0900, 32'h0000_0904, 1'b1, 32'h0000_7777, 0, 0, 2'b01, 32'h0};

        rst           = 1'b0;
        req_valid     = 2'b11;
        req_addr[0]   = 32'h0;
        req_addr[1]   = 32'h0;
        c_hit         = 1'b0;
        c_data        = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        // Reset values, with requests asserted to check the grant is held off.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_hit", 64'(rsp_hit), 64'(0));
        chk("rst_c_lookup", 64'(c_lookup), 64'(0));
        chk("rst_c_fill", 64'(c_fill), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_c_addr", 64'(c_addr), 64'(0));
        chk("rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
`ifdef CACHE_SCHED_PERF_EN
        chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("rst_miss_cnt", 64'(miss_cnt), 64'(0));
`endif

        // Contention: both requesters hold valid, all hits; grants alternate from 0.
        req_addr[0] = 32'h0000_0500;
        req_addr[1] = 32'h0000_0600;
        c_hit       = 1'b1;
        c_data      = 32'h0000_ABCD;
        rst         = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int t = 0; t < 10; t++) begin
                if (req_ready != 2'b00) begin
                    got = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) chk("contention_timeout", 64'(0), 64'(1));
            else chk("contention_grant", 64'(req_ready), (k % 2 == 0) ? 64'(1) : 64'(2));
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        // Table vectors.
        exp_hits = 4;
        exp_miss = 0;
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].hit) exp_hits++;
            else exp_miss++;
        end
`ifdef CACHE_SCHED_PERF_EN
        @(negedge clk);
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
`endif

        // Spurious memory response while idle.
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_9999;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            chk_quiet("spurious_quiet");
            @(negedge clk);
        end

        // Reset while in MEM_WAIT, then a late memory response.
        req_valid   = 2'b01;
        req_addr[0] = 32'h0000_0080;
        c_hit       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            if (mem_req_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_mem_req_seen", 64'(seen), 64'(1));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        rst           = 1'b1;
        chk_quiet("abort_after_reset");
`ifdef CACHE_SCHED_PERF_EN
        chk("abort_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("abort_miss_cnt", 64'(miss_cnt), 64'(0));
`endif
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_8888;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk_quiet("abort_quiet");
            @(negedge clk);
        end

        // Normal service after the abort; pointer restarts at requester 0.
        run_vec(vecs[7]);
`ifdef CACHE_SCHED_PERF_EN
        @(negedge clk);
        chk("post_hit_cnt", 64'(hit_cnt), 64'(1));
        chk("post_miss_cnt", 64'(miss_cnt), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
